// File: rtl/conv3x3_sched.sv
// Sequencer for the 3x3 INT8 MAC array: weight load, column streaming, window tagging and result alignment.
// Optional ReLU clamp on results when CONV_RELU_EN is defined.
module conv3x3_sched #(
  parameter int IMG_W   = 480,
  parameter int IMG_H   = 272,
  parameter int MAC_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               wt_valid,
  input  logic signed [7:0]  wt_data,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic signed [7:0]  pix_d1,
  input  logic signed [7:0]  pix_d2,
  input  logic signed [7:0]  pix_d3,
  output logic               valid_in,
  output logic signed [7:0]  din_1,
  output logic signed [7:0]  din_2,
  output logic signed [7:0]  din_3,
  output logic signed [7:0]  weight_11,
  output logic signed [7:0]  weight_12,
  output logic signed [7:0]  weight_13,
  output logic signed [7:0]  weight_21,
  output logic signed [7:0]  weight_22,
  output logic signed [7:0]  weight_23,
  output logic signed [7:0]  weight_31,
  output logic signed [7:0]  weight_32,
  output logic signed [7:0]  weight_33,
  input  logic signed [17:0] mac_dout,
  output logic               res_valid,
  output logic signed [17:0] res_data,
  output logic               res_last,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = $clog2(MAC_LAT + 2);

  typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          wt_cnt;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [DW-1:0]       drain_cnt;
  logic                accept;
  logic                beat_is_last;
  logic                beat_win;
  logic                beat_last;
  logic [MAC_LAT-1:0]  tag_v;
  logic [MAC_LAT-1:0]  tag_l;
  logic signed [7:0]   wts [9];

  assign accept       = (state == RUN) && pix_valid;
  assign beat_is_last = (row == RW'(IMG_H - 3)) && (col == CW'(IMG_W - 1));
  assign pix_ready    = (state == RUN);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  assign weight_11 = wts[0];
  assign weight_12 = wts[1];
  assign weight_13 = wts[2];
  assign weight_21 = wts[3];
  assign weight_22 = wts[4];
  assign weight_23 = wts[5];
  assign weight_31 = wts[6];
  assign weight_32 = wts[7];
  assign weight_33 = wts[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD_W;
      LOAD_W:  if (wt_valid && wt_cnt == 4'd8) state_nxt = RUN;
      RUN:     if (accept && beat_is_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DW'(MAC_LAT)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Position counters hold during pix_valid gaps; row stops at the last output row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_cnt    <= '0;
      col       <= '0;
      row       <= '0;
      drain_cnt <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        wt_cnt <= '0;
        col    <= '0;
        row    <= '0;
      end
      if (state == LOAD_W && wt_valid) wt_cnt <= wt_cnt + 1'b1;
      if (accept) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          if (!beat_is_last) row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) wts[i] <= '0;
    end else if (state == LOAD_W && wt_valid) begin
      for (int i = 0; i < 9; i++)
        if (wt_cnt == 4'(i)) wts[i] <= wt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_in  <= 1'b0;
      din_1     <= '0;
      din_2     <= '0;
      din_3     <= '0;
      beat_win  <= 1'b0;
      beat_last <= 1'b0;
    end else begin
      valid_in  <= accept;
      beat_win  <= accept && (col >= CW'(2));
      beat_last <= accept && beat_is_last;
      if (accept) begin
        din_1 <= pix_d1;
        din_2 <= pix_d2;
        din_3 <= pix_d3;
      end
    end
  end

  // Tags travel beside the array so they meet mac_dout in the cycle it is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v     <= '0;
      tag_l     <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_data  <= '0;
    end else begin
      for (int i = MAC_LAT - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
      tag_v[0]  <= beat_win;
      tag_l[0]  <= beat_last;
      res_valid <= tag_v[MAC_LAT-1];
      res_last  <= tag_l[MAC_LAT-1];
`ifdef CONV_RELU_EN
      res_data  <= mac_dout[17] ? '0 : mac_dout;
`else
      res_data  <= mac_dout;
`endif
    end
  end

endmodule

// File: doc/conv3x3_sched.md
# conv3x3_sched

Sequencer for the 3×3 INT8 multiply-accumulate array `cal_multi_3INT8`. It loads the nine signed weights serially and streams one column of three vertically adjacent pixels per accepted beat into the array. It tracks column and row position, discards results from incomplete windows, and returns aligned results with an end-of-frame marker. It sits between the line buffer (which supplies three rows per column) and the downstream result writer.

## Interface
- `IMG_W`, 480, pixels per input row; must be ≥ 3.
- `IMG_H`, 272, input rows per frame; must be ≥ 3. The frame yields `IMG_H-2` output rows.
- `MAC_LAT`, 3, cycles from `valid_in` at the array to valid `dout`; must be ≥ 1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle frame start; honoured only in IDLE.
- `wt_valid`  in  1  weight word strobe.
- `wt_data`  in  8  signed weight, row-major order w11, w12, w13, w21 … w33.
- `pix_valid`  in  1  pixel column available.
- `pix_ready`  out  1  column accepted when `pix_valid & pix_ready`.
- `pix_d1`, `pix_d2`, `pix_d3`  in  8 each  signed pixels, rows r, r+1, r+2.
- `valid_in`  out  1  to array.
- `din_1`, `din_2`, `din_3`  out  8 each  to array.
- `weight_11` … `weight_33`  out  8 each  to array; registered and stable outside LOAD_W.
- `mac_dout`  in  18  signed array result.
- `res_valid`  out  1  result strobe; no backpressure.
- `res_data`  out  18  signed result.
- `res_last`  out  1  with the final result of the frame.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- FSM states: IDLE → LOAD_W → RUN → DRAIN → DONE → IDLE.
- **IDLE**
  - `pix_ready` = 0.
  - On `start`: clear `wt_cnt`, `col`, `row` and go to LOAD_W.
- **LOAD_W**
  - Each `wt_valid` writes `wt_data` into weight slot `wt_cnt` and increments `wt_cnt`.
  - When the 9th word (`wt_cnt` = 8) is written, go to RUN.
  - `pix_ready` = 0.
- **RUN**
  - `pix_ready` = 1.
  - Each accepted beat registers `pix_d1..3` into `din_1..3` and asserts `valid_in` for one cycle.
  - `col` counts 0 … `IMG_W-1` and wraps to 0. On wrap, `row` increments (0 … `IMG_H-3`).
  - The beat is tagged "window-valid" when `col` ≥ 2.
  - The beat is tagged "last" when `row` = `IMG_H-3` and `col` = `IMG_W-1`. Accepting the last beat moves the FSM to DRAIN.
- **DRAIN**
  - `pix_ready` = 0.
  - Wait `MAC_LAT+1` cycles so the last result can emerge, then go to DONE.
- **DONE**
  - Pulse `done` for one cycle, then go to IDLE. Weights are retained.
- **Tag pipeline**
  - A `MAC_LAT`-deep shift register carries {valid & window-valid, last}.
  - At its output stage: `res_data` ← `mac_dout`, `res_valid` ← tag valid, `res_last` ← tag last.
  - Results from beats with `col` < 2 never assert `res_valid`.
- **Ignored inputs**
  - `wt_valid` is ignored outside LOAD_W.
  - `start` is ignored when not IDLE.
  - `pix_valid` is ignored outside RUN.
- **Result count**: exactly (`IMG_W-2`)·(`IMG_H-2`) `res_valid` pulses per frame.
- **Widths**
  - `col`: `$clog2(IMG_W)` bits.
  - `row`: `$clog2(IMG_H)` bits.
  - `wt_cnt`: 4 bits.
  - `res_data` is `mac_dout` passed through unchanged, except in the configured case (see Configuration).

## Timing
- **Reset values**: all outputs 0, including `weight_*`, `din_*`, `res_data`, `pix_ready`, `busy` and `done`. FSM is IDLE; all counters and tag stages are 0.
- **Reset mid-operation**
  - All state and outputs clear immediately and asynchronously.
  - In-flight tags are dropped; no `res_valid` or `done` follows.
  - Weights must be reloaded.
- **Start to weight load**: `start` at cycle t → `busy` = 1 at t+1, state LOAD_W at t+1.
- **Weights to RUN**: 9th `wt_valid` at cycle t → `pix_ready` = 1 at t+1.
- **Beat to array**: beat accepted at cycle t → `din_*` / `valid_in` at t+1.
- **Array to result**: `mac_dout` sampled at t+1+`MAC_LAT`; `res_valid` visible at t+2+`MAC_LAT`. The end-to-end latency from acceptance to result is `MAC_LAT+2`.
- **Frame end**: `done` pulses exactly one cycle after the DRAIN wait ends. `res_last` is always seen before or in the same cycle as `done`, never after.
- **Stalls**: `pix_valid` gaps are allowed in RUN; counters hold during a gap.
- **Back-to-back frames**: `start` in the cycle after `done` (IDLE) is accepted.

## Configuration
- **`CONV_RELU_EN` defined**: when `res_valid` is asserted, a negative `mac_dout` is written to `res_data` as 0. Non-negative values pass through unchanged.
- **`CONV_RELU_EN` not defined**: `res_data` is the raw signed `mac_dout`. No clamp logic is present.

## Test plan
All scenarios use `IMG_W`=8, `IMG_H`=4, `MAC_LAT`=3, with a behavioural array model.
- **Full frame**
  - Stimulus: weights 1, 2, 3, 1, 2, 3, 1, 2, 3; all pixels 1; continuous `pix_valid`.
  - Required: 12 `res_valid` pulses, each `res_data` = 18.
  - Required: `res_last` on the 12th pulse, `done` after it, `busy` low after `done`.
- **Latency check**: first accepted beat at cycle t → `valid_in` at t+1; first `res_valid` (beat with `col` = 2) at t+2+2+`MAC_LAT` = t+7.
- **Stalls and ignored inputs**
  - Stimulus: same frame with `pix_valid` toggling 1-0-1-0.
  - Required: still 12 results with unchanged values.
  - Stimulus: `start` and `wt_valid` asserted during RUN.
  - Required: both ignored; weights unchanged.
- **ReLU**
  - Stimulus: all weights −1, pixels 1.
  - Required with `CONV_RELU_EN`: `res_data` = 0.
  - Required without it: `res_data` = −9 (18-bit two's complement 0x3FFF7).
- **Reset mid-frame**
  - Stimulus: drop `rst_n` after 10 beats.
  - Required: all outputs 0 at once; no `done`.
  - Required: a fresh `start` plus full weight load yields a correct 12-result frame.
- **Back-to-back frames**
  - Stimulus: `start` the cycle after `done`, reload the same weights.
  - Required: the second frame yields 12 results; `res_last` is asserted twice in total.
